jtag_scan_master: RTL

- Host-side JTAG initiator: drives TCK/TMS/TDI and captures TDO to perform complete IR or DR scans through a standard IEEE 1149.1 TAP.
- Used to exercise on-chip virtual-JTAG debug targets, such as the Nios II debug module, from on-chip logic or a bench.
- Accepts one scan command at a time and returns the captured TDO bits through a valid/ready response.
- Idles with the target TAP parked in Run-Test/Idle.

---
 rtl/jtag_scan_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/jtag_scan_master.sv
// JTAG scan master: drives TCK/TMS/TDI to run one complete IR scan, DR scan or
// TAP reset per command, and returns the captured TDO bits through a
// valid/ready response. Between commands the target TAP rests in Run-Test/Idle.
module jtag_scan_master #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_tdi,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_tdo,
    output logic               rsp_error,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);

    // Period counter must cover len + 6 TCK periods.
    localparam int CNT_W = LEN_W + 2;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] OP_DR  = 2'b00;
    localparam logic [1:0] OP_IR  = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_tdi;
    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   r_bit;
    logic [DIV_W-1:0]   r_div;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [MAX_LEN-1:0] r_rsp_tdo;
    logic               r_rsp_error;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi_o;
    logic               r_busy;

    logic               w_bad;
    logic [CNT_W-1:0]   w_total;
    logic [CNT_W-1:0]   w_nbit;
    logic [CNT_W-1:0]   w_pre;
    logic [CNT_W-1:0]   w_shi;
    logic               w_cur_shift;
    logic               w_nxt_shift;
    logic [IDX_W-1:0]   w_cur_idx;
    logic [IDX_W-1:0]   w_nxt_idx;
    logic               w_nxt_tms;
    logic               w_div_end;

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_tdo   = r_rsp_tdo;
    assign rsp_error = r_rsp_error;
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi_o;
    assign busy      = r_busy;

    // Command validation and TCK period count, from the live command fields.
    always_comb begin
        w_bad = (cmd_op == 2'b11) ||
                ((cmd_op != OP_RST) &&
                 ((cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN))));
        case (cmd_op)
            OP_RST:  w_total = CNT_W'(6);
            OP_IR:   w_total = CNT_W'(cmd_len) + CNT_W'(6);
            default: w_total = CNT_W'(cmd_len) + CNT_W'(5);
        endcase
    end

    // Shift window and TMS for the current and the upcoming TCK period.
    // Shift bits occupy periods [w_pre, w_shi); w_shi is Exit1->Update, w_shi+1 Update->Idle.
    always_comb begin
        w_nbit      = r_bit + 1'b1;
        w_pre       = (r_op == OP_IR) ? CNT_W'(4) : CNT_W'(3);
        w_shi       = w_pre + CNT_W'(r_len);
        w_cur_shift = (r_op != OP_RST) && (r_bit >= w_pre) && (r_bit < w_shi);
        w_nxt_shift = (r_op != OP_RST) && (w_nbit >= w_pre) && (w_nbit < w_shi);
        w_cur_idx   = IDX_W'(r_bit - w_pre);
        w_nxt_idx   = IDX_W'(w_nbit - w_pre);
        w_div_end   = (r_div == DIV_W'(CLK_DIV - 1));
        w_nxt_tms   = 1'b0;
        if (r_op == OP_RST)
            w_nxt_tms = (w_nbit < CNT_W'(5));
        else if (w_nbit < w_pre)
            w_nxt_tms = (r_op == OP_IR) && (w_nbit == CNT_W'(1));
        else if (w_nbit < w_shi)
            w_nxt_tms = (w_nbit == w_shi - 1'b1);
        else
            w_nxt_tms = (w_nbit == w_shi);
    end

    // Control FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_DR;
            r_len       <= '0;
            r_tdi       <= '0;
            r_total     <= '0;
            r_bit       <= '0;
            r_div       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_tdo   <= '0;
            r_rsp_error <= 1'b0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi_o     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_op        <= cmd_op;
                        r_len       <= cmd_len;
                        r_tdi       <= cmd_tdi;
                        r_total     <= w_total;
                        r_cmd_ready <= 1'b0;
                        r_rsp_tdo   <= '0;
                        if (w_bad) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                        end else begin
                            // Period 0 begins now: every sequence leaves Idle with TMS=1.
                            r_state <= S_SCAN;
                            r_busy  <= 1'b1;
                            r_bit   <= '0;
                            r_div   <= '0;
                            r_tck   <= 1'b0;
                            r_tms   <= 1'b1;
                            r_tdi_o <= 1'b0;
                        end
                    end
                end
                S_SCAN: begin
                    if (!w_div_end) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_tck) begin
                            // Rising edge: target has held TDO stable since the falling edge.
                            r_tck <= 1'b1;
                            if (w_cur_shift)
                                r_rsp_tdo[w_cur_idx] <= tdo;
                        end else begin
                            r_tck <= 1'b0;
                            if (r_bit == r_total - 1'b1) begin
                                r_state     <= S_RESP;
                                r_busy      <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_tms       <= 1'b0;
                                r_tdi_o     <= 1'b0;
                            end else begin
                                r_bit   <= w_nbit;
                                r_tms   <= w_nxt_tms;
                                r_tdi_o <= w_nxt_shift ? r_tdi[w_nxt_idx] : 1'b0;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_error <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
